// File: rtl/apb_layer_seq_pkg.sv
// apb_layer_seq_pkg: shared encodings for the APB layer-configuration sequencer.
package apb_layer_seq_pkg;
    typedef enum logic [1:0] {
        ENG_FC      = 2'd0,
        ENG_CONV    = 2'd1,
        ENG_POOL    = 2'd2,
        ENG_ILLEGAL = 2'd3
    } eng_e;
    typedef enum logic {
        OP_WR   = 1'b0,
        OP_POLL = 1'b1
    } op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_ERROR
    } state_e;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SLV     = 2'd1;
    localparam logic [1:0] ERR_ENG     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/apb_layer_seq.sv
// apb_layer_seq: APB master that runs write/poll configuration commands on the FC/CONV/POOL engines.
// Optional poll timeout (ERR_CODE 3) is compiled in with APB_LAYER_SEQ_TIMEOUT_EN.
module apb_layer_seq
    import apb_layer_seq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int POLL_GAP = 16
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W   = 20,
    parameter int TIMEOUT_MAX = 1000000
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_ENGINE,
    input  logic              CMD_OP,
    input  logic              CMD_LAST,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [31:0]       CMD_DATA,
    input  logic              ERR_CLR,
    output logic [ADDR_W-1:0] PADDR,
    output logic [2:0]        PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              BUSY,
    output logic              LAYER_DONE,
    output logic              ERR,
    output logic [1:0]        ERR_CODE
);
    localparam int GW = $clog2(POLL_GAP + 1);

    state_e            state_q, state_d;
    eng_e              eng_q, eng_d;
    op_e               op_q, op_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              done_q, done_d;
    logic              hit;
    logic              active;
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] poll_cnt_q, poll_cnt_d;
`endif

    assign hit = |(PRDATA & data_q);

    always_comb begin
        state_d    = state_q;
        eng_d      = eng_q;
        op_d       = op_q;
        last_d     = last_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gap_d      = gap_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (CMD_VALID) begin
                eng_d  = eng_e'(CMD_ENGINE);
                op_d   = op_e'(CMD_OP);
                last_d = CMD_LAST;
                addr_d = CMD_ADDR;
                data_d = CMD_DATA;
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                if (CMD_ENGINE == ENG_ILLEGAL) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_ENG;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: if (PREADY) begin
                if (PSLVERR) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_SLV;
                end else if (op_q == OP_WR || hit) begin
                    state_d = S_IDLE;
                    done_d  = last_q;
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
                end else if (poll_cnt_q == TIMEOUT_W'(TIMEOUT_MAX - 1)) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    state_d    = S_GAP;
                    gap_d      = '0;
                    poll_cnt_d = poll_cnt_q + TIMEOUT_W'(1);
                end
`else
                end else begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
`endif
            end
            S_GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == GW'(POLL_GAP - 1)) ? S_SETUP : S_GAP;
            end
            S_ERROR: if (ERR_CLR) begin
                state_d    = S_IDLE;
                err_code_d = ERR_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            eng_q      <= ENG_FC;
            op_q       <= OP_WR;
            last_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            eng_q      <= eng_d;
            op_q       <= op_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
        end
    end

`ifdef APB_LAYER_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) poll_cnt_q <= '0;
        else poll_cnt_q <= poll_cnt_d;
    end
`endif

    // Bus outputs decode from registered state, so an async reset idles the bus at once.
    assign active     = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PSEL       = active ? (3'b001 << eng_q) : 3'b000;
    assign PENABLE    = state_q == S_ACCESS;
    assign PWRITE     = active && op_q == OP_WR;
    assign PADDR      = active ? addr_q : '0;
    assign PWDATA     = (active && op_q == OP_WR) ? data_q : '0;
    assign CMD_READY  = state_q == S_IDLE && !RESET;
    assign BUSY       = state_q != S_IDLE;
    assign LAYER_DONE = done_q;
    assign ERR        = state_q == S_ERROR;
    assign ERR_CODE   = err_code_q;
endmodule

// File: tb/tb_apb_layer_seq.sv
// tb_apb_layer_seq: scoreboard bench; stimulus queues expected APB transfers, a monitor checks every bus cycle.
module tb_apb_layer_seq;
    logic        CLK = 1'b0, RESET = 1'b0;
    logic        CMD_VALID = 1'b0, CMD_OP = 1'b0, CMD_LAST = 1'b0, ERR_CLR = 1'b0;
    logic [1:0]  CMD_ENGINE = 2'd0;
    logic [31:0] CMD_ADDR = '0, CMD_DATA = '0;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic        CMD_READY, PENABLE, PWRITE, BUSY, LAYER_DONE, ERR;
    logic [2:0]  PSEL;
    logic [31:0] PADDR, PWDATA;
    logic [1:0]  ERR_CODE;

    typedef struct packed {
        logic [2:0]  psel;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    int          wait_n = 0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;
    int          n_vec = 0, n_err = 0;
    int          done_cnt = 0, psel_cycles = 0;

    always #5 CLK = ~CLK;

    apb_layer_seq #(
        .ADDR_W(32),
        .POLL_GAP(16)
`ifdef APB_LAYER_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_W(20),
        .TIMEOUT_MAX(5)
`endif
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ENGINE(CMD_ENGINE),
        .CMD_OP(CMD_OP), .CMD_LAST(CMD_LAST), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .ERR_CLR(ERR_CLR),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .BUSY(BUSY), .LAYER_DONE(LAYER_DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: PREADY after wait_n wait states, read data from rd_q.
    always @(posedge CLK) begin
        #2;
        if (PSEL != 3'b000 && PENABLE) begin
            PREADY  = (acc_cnt == wait_n);
            PSLVERR = PREADY && slv_err;
            PRDATA  = '0;
            if (PREADY && rd_q.size() > 0) PRDATA = rd_q.pop_front();
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = '0;
            acc_cnt = 0;
        end
    end

    // Monitor: every selected bus cycle must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (LAYER_DONE) done_cnt++;
            if (PSEL != 3'b000) begin
                psel_cycles++;
                chk("psel_onehot", $countones(PSEL), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", {29'd0, PSEL}, 0);
                end else begin
                    chk("psel", {29'd0, PSEL}, {29'd0, exp_q[0].psel});
                    chk("pwrite", {31'd0, PWRITE}, {31'd0, exp_q[0].pwrite});
                    chk("paddr", PADDR, exp_q[0].paddr);
                    chk("pwdata", PWDATA, exp_q[0].pwdata);
                    if (PENABLE && PREADY) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [1:0] eng, input logic op, input logic last,
                        input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        CMD_VALID  = 1'b1;
        CMD_ENGINE = eng;
        CMD_OP     = op;
        CMD_LAST   = last;
        CMD_ADDR   = addr;
        CMD_DATA   = data;
        for (int i = 0; i < 200 && !CMD_READY; i++) @(negedge CLK);
        chk("cmd_ready_wait", {31'd0, CMD_READY}, 1);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        @(negedge CLK);
        while (BUSY && n < budget) begin
            n++;
            @(negedge CLK);
        end
        chk("idle_timeout", {31'd0, BUSY}, 0);
    endtask

    task automatic clear_err();
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, d0, p0;
        #1 RESET = 1'b1;
        #1;
        chk("rst_cmd_ready", {31'd0, CMD_READY}, 0);
        chk("rst_psel", {29'd0, PSEL}, 0);
        chk("rst_busy_err", {29'd0, BUSY, ERR, PENABLE}, 0);
        chk("rst_err_code", {30'd0, ERR_CODE}, 0);
        chk("rst_done", {31'd0, LAYER_DONE}, 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("idle_cmd_ready", {31'd0, CMD_READY}, 1);

        // Minimum-latency FC write
        exp_q.push_back('{3'b001, 1'b1, 32'h10, 32'hDEADBEEF});
        send(2'd0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
        @(negedge CLK);
        chk("c1_psel", {29'd0, PSEL}, 32'h1);
        chk("c1_penable", {31'd0, PENABLE}, 0);
        chk("c1_cmd_ready", {31'd0, CMD_READY}, 0);
        @(negedge CLK);
        chk("c2_psel", {29'd0, PSEL}, 32'h1);
        chk("c2_penable", {31'd0, PENABLE}, 1);
        @(negedge CLK);
        chk("c3_psel", {29'd0, PSEL}, 0);
        chk("c3_cmd_ready", {31'd0, CMD_READY}, 1);

        // CONV write, last, 4 wait states
        wait_n = 4;
        d0 = done_cnt;
        exp_q.push_back('{3'b010, 1'b1, 32'h24, 32'h0BADF00D});
        send(2'd1, 1'b0, 1'b1, 32'h24, 32'h0BADF00D);
        wait_idle(50, n);
        chk("conv_busy_cycles", n, 6);
        repeat (3) @(negedge CLK);
        chk("conv_done_pulses", done_cnt - d0, 1);
        chk("conv_done_low", {31'd0, LAYER_DONE}, 0);
        wait_n = 0;

        // POOL poll, mask 0x1, met on 4th read
        d0 = done_cnt;
        rd_q = '{32'h0, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) exp_q.push_back('{3'b100, 1'b0, 32'h40, 32'h0});
        send(2'd2, 1'b1, 1'b0, 32'h40, 32'h1);
        wait_idle(200, n);
        chk("poll_busy_cycles", n, 56);
        repeat (2) @(negedge CLK);
        chk("poll_reads_left", exp_q.size(), 0);
        chk("poll_rd_used", rd_q.size(), 0);
        chk("poll_no_done", done_cnt - d0, 0);

        // PSLVERR on FC write
        slv_err = 1'b1;
        d0 = done_cnt;
        exp_q.push_back('{3'b001, 1'b1, 32'h20, 32'h12345678});
        send(2'd0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        repeat (3) @(negedge CLK);
        slv_err = 1'b0;
        chk("slv_err", {31'd0, ERR}, 1);
        chk("slv_err_code", {30'd0, ERR_CODE}, 1);
        chk("slv_cmd_ready", {31'd0, CMD_READY}, 0);
        chk("slv_psel", {29'd0, PSEL}, 0);
        repeat (5) @(negedge CLK);
        chk("slv_err_sticky", {30'd0, ERR, CMD_READY}, 32'h2);
        clear_err();
        chk("slv_clr_err", {29'd0, ERR, ERR_CODE}, 0);
        chk("slv_clr_ready", {31'd0, CMD_READY}, 1);
        chk("slv_no_done", done_cnt - d0, 0);

        // ERR_CLR while idle has no effect
        clear_err();
        chk("idle_clr", {29'd0, BUSY, ERR, CMD_READY}, 1);

        // Illegal engine
        p0 = psel_cycles;
        d0 = done_cnt;
        send(2'd3, 1'b0, 1'b1, 32'h30, 32'hAA);
        repeat (3) @(negedge CLK);
        chk("ill_err", {31'd0, ERR}, 1);
        chk("ill_err_code", {30'd0, ERR_CODE}, 2);
        chk("ill_no_bus", psel_cycles - p0, 0);
        clear_err();
        chk("ill_clr", {29'd0, ERR, ERR_CODE}, 0);
        chk("ill_no_done", done_cnt - d0, 0);

`ifdef APB_LAYER_SEQ_TIMEOUT_EN
        // Mask never met: 5 reads then timeout
        for (int i = 0; i < 5; i++) exp_q.push_back('{3'b001, 1'b0, 32'h60, 32'h0});
        send(2'd0, 1'b1, 1'b0, 32'h60, 32'h0);
        for (int i = 0; i < 200 && !ERR; i++) @(negedge CLK);
        chk("to_err", {31'd0, ERR}, 1);
        chk("to_err_code", {30'd0, ERR_CODE}, 3);
        chk("to_reads", exp_q.size(), 0);
        clear_err();
`endif

        // Async reset in the middle of a long ACCESS
        wait_n = 50;
        exp_q.push_back('{3'b010, 1'b1, 32'h50, 32'hCAFEF00D});
        send(2'd1, 1'b0, 1'b0, 32'h50, 32'hCAFEF00D);
        for (int i = 0; i < 10 && !PENABLE; i++) @(negedge CLK);
        chk("rst_mid_access", {31'd0, PENABLE}, 1);
        #2 RESET = 1'b1;
        #1;
        chk("rst_mid_psel", {29'd0, PSEL}, 0);
        chk("rst_mid_bus", {30'd0, PENABLE, BUSY}, 0);
        chk("rst_mid_paddr", PADDR, 0);
        exp_q.delete();
        wait_n = 0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", {31'd0, CMD_READY}, 1);

        exp_q.push_back('{3'b001, 1'b1, 32'h70, 32'h5A5A5A5A});
        send(2'd0, 1'b0, 1'b0, 32'h70, 32'h5A5A5A5A);
        wait_idle(20, n);
        chk("post_rst_write", n, 2);
        chk("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
